// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use hazard detection.
// Captures decoded control, operands and register indices every cycle and
// presents them to the execute stage. A load in EX whose destination feeds
// the instruction in ID forces a one-cycle bubble and stalls the front end.
// A branch flush kills the instruction entering EX. A global hold freezes EX.
module id_ex_pipe #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 9,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              hold,
    input  logic              id_valid,
    input  logic [2:0]        id_ALUOp,
    input  logic [6:0]        id_Funct7,
    input  logic [2:0]        id_Funct3,
    input  logic              id_ALUSrc,
    input  logic              id_MemtoReg,
    input  logic              id_RegWrite,
    input  logic              id_MemRead,
    input  logic              id_MemWrite,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic [DATA_W-1:0] id_RD1,
    input  logic [DATA_W-1:0] id_RD2,
    input  logic [DATA_W-1:0] id_Imm,
    input  logic [PC_W-1:0]   id_PC,
    output logic              ex_valid,
    output logic [2:0]        ex_ALUOp,
    output logic [6:0]        ex_Funct7,
    output logic [2:0]        ex_Funct3,
    output logic              ex_ALUSrc,
    output logic              ex_MemtoReg,
    output logic              ex_RegWrite,
    output logic              ex_MemRead,
    output logic              ex_MemWrite,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic [DATA_W-1:0] ex_RD1,
    output logic [DATA_W-1:0] ex_RD2,
    output logic [DATA_W-1:0] ex_Imm,
    output logic [PC_W-1:0]   ex_PC,
    output logic              stall,
    output logic [CNT_W-1:0]  bubble_cnt
);

    // Everything the EX stage holds, kept as one register so a bubble is a
    // single all-zero assignment.
    typedef struct packed {
        logic              valid;
        logic [2:0]        alu_op;
        logic [6:0]        funct7;
        logic [2:0]        funct3;
        logic              alu_src;
        logic              memto_reg;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] imm;
        logic [PC_W-1:0]   pc;
    } ex_reg_t;

    localparam ex_reg_t          BUBBLE       = {$bits(ex_reg_t){1'b0}};
    localparam logic [2:0]       ALUOP_BRANCH = 3'b001;
    localparam logic [2:0]       ALUOP_RTYPE  = 3'b010;
    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};

    ex_reg_t          ex_d;
    ex_reg_t          ex_q;
    ex_reg_t          id_pkt_s;
    logic [CNT_W-1:0] bubble_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q;
    logic             uses_rs2_s;
    logic             hazard_s;

    // Gather the decode-stage fields into the EX record layout.
    always_comb begin
        id_pkt_s           = BUBBLE;
        id_pkt_s.valid     = id_valid;
        id_pkt_s.alu_op    = id_ALUOp;
        id_pkt_s.funct7    = id_Funct7;
        id_pkt_s.funct3    = id_Funct3;
        id_pkt_s.alu_src   = id_ALUSrc;
        id_pkt_s.memto_reg = id_MemtoReg;
        id_pkt_s.reg_write = id_RegWrite;
        id_pkt_s.mem_read  = id_MemRead;
        id_pkt_s.mem_write = id_MemWrite;
        id_pkt_s.rs1       = id_rs1;
        id_pkt_s.rs2       = id_rs2;
        id_pkt_s.rd        = id_rd;
        id_pkt_s.rd1       = id_RD1;
        id_pkt_s.rd2       = id_RD2;
        id_pkt_s.imm       = id_Imm;
        id_pkt_s.pc        = id_PC;
    end

    // Load-use detection: rs1 is always treated as read; rs2 only for
    // branches, R-type and stores. x0 is never a real dependency.
    always_comb begin
        uses_rs2_s = (id_ALUOp == ALUOP_BRANCH) | (id_ALUOp == ALUOP_RTYPE) | id_MemWrite;
        hazard_s   = ex_q.valid & ex_q.mem_read & (ex_q.rd != 5'd0) & id_valid &
                     ((ex_q.rd == id_rs1) | (uses_rs2_s & (ex_q.rd == id_rs2)));
    end

    assign stall = hold | hazard_s;

    // Next EX contents: flush beats hold beats hazard beats a normal load.
    // Only a hazard bubble that actually reaches EX is counted.
    always_comb begin
        ex_d         = ex_q;
        bubble_cnt_d = bubble_cnt_q;
        if (flush) begin
            ex_d = BUBBLE;
        end else if (hold) begin
            ex_d = ex_q;
        end else if (hazard_s) begin
            ex_d = BUBBLE;
            if (bubble_cnt_q != CNT_MAX) begin
                bubble_cnt_d = bubble_cnt_q + CNT_ONE;
            end else begin
                bubble_cnt_d = bubble_cnt_q;
            end
        end else if (id_valid) begin
            ex_d = id_pkt_s;
        end else begin
            // An empty decode slot enters EX as a bubble so it can never write state.
            ex_d = BUBBLE;
        end
    end

    // EX register and bubble counter, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q         <= BUBBLE;
            bubble_cnt_q <= CNT_ZERO;
        end else begin
            ex_q         <= ex_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign ex_valid    = ex_q.valid;
    assign ex_ALUOp    = ex_q.alu_op;
    assign ex_Funct7   = ex_q.funct7;
    assign ex_Funct3   = ex_q.funct3;
    assign ex_ALUSrc   = ex_q.alu_src;
    assign ex_MemtoReg = ex_q.memto_reg;
    assign ex_RegWrite = ex_q.reg_write;
    assign ex_MemRead  = ex_q.mem_read;
    assign ex_MemWrite = ex_q.mem_write;
    assign ex_rs1      = ex_q.rs1;
    assign ex_rs2      = ex_q.rs2;
    assign ex_rd       = ex_q.rd;
    assign ex_RD1      = ex_q.rd1;
    assign ex_RD2      = ex_q.rd2;
    assign ex_Imm      = ex_q.imm;
    assign ex_PC       = ex_q.pc;
    assign bubble_cnt  = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Testbench for id_ex_pipe: directed vector table, hand-written corner
// sequences (async reset, multi-cycle hold, counter saturation) and a
// randomized phase, all checked against an instruction-level reference model.
module tb_id_ex_pipe;

    localparam int DATA_W  = 32;
    localparam int PC_W    = 9;
    localparam int CNT_W   = 8;   // narrow counter so saturation is reachable quickly
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset, flush, hold, id_valid;
    logic [2:0]        id_ALUOp, id_Funct3;
    logic [6:0]        id_Funct7;
    logic              id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead, id_MemWrite;
    logic [4:0]        id_rs1, id_rs2, id_rd;
    logic [DATA_W-1:0] id_RD1, id_RD2, id_Imm;
    logic [PC_W-1:0]   id_PC;
    logic              ex_valid;
    logic [2:0]        ex_ALUOp, ex_Funct3;
    logic [6:0]        ex_Funct7;
    logic              ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead, ex_MemWrite;
    logic [4:0]        ex_rs1, ex_rs2, ex_rd;
    logic [DATA_W-1:0] ex_RD1, ex_RD2, ex_Imm;
    logic [PC_W-1:0]   ex_PC;
    logic              stall;
    logic [CNT_W-1:0]  bubble_cnt;

    always #5 clk = ~clk;

    id_ex_pipe #(.DATA_W(DATA_W), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .flush(flush), .hold(hold), .id_valid(id_valid),
        .id_ALUOp(id_ALUOp), .id_Funct7(id_Funct7), .id_Funct3(id_Funct3),
        .id_ALUSrc(id_ALUSrc), .id_MemtoReg(id_MemtoReg), .id_RegWrite(id_RegWrite),
        .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_RD1(id_RD1), .id_RD2(id_RD2), .id_Imm(id_Imm), .id_PC(id_PC),
        .ex_valid(ex_valid), .ex_ALUOp(ex_ALUOp), .ex_Funct7(ex_Funct7), .ex_Funct3(ex_Funct3),
        .ex_ALUSrc(ex_ALUSrc), .ex_MemtoReg(ex_MemtoReg), .ex_RegWrite(ex_RegWrite),
        .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_RD1(ex_RD1), .ex_RD2(ex_RD2), .ex_Imm(ex_Imm), .ex_PC(ex_PC),
        .stall(stall), .bubble_cnt(bubble_cnt)
    );

    typedef struct packed {
        logic        flush;
        logic        hold;
        logic        valid;
        logic [2:0]  aluop;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic        alusrc;
        logic        memtoreg;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [8:0]  pc;
    } instr_t;

    typedef struct {
        instr_t     in;
        logic       exp_stall;
        logic       exp_valid;
        logic [4:0] exp_rd;
        int         exp_cnt;
    } vec_t;

    int     n_vec = 0;
    int     n_err = 0;
    instr_t m_ex;     // what the model says EX holds
    int     m_cnt;    // model bubble count
    vec_t   tbl[20];

    function automatic instr_t mk(logic v, logic [2:0] op, logic [6:0] f7, logic [2:0] f3,
                                  logic src, logic m2r, logic rw, logic mr, logic mw,
                                  logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                                  logic [31:0] imm);
        instr_t t;
        t = '0;
        t.valid = v; t.aluop = op; t.f7 = f7; t.f3 = f3;
        t.alusrc = src; t.memtoreg = m2r; t.regwrite = rw; t.memread = mr; t.memwrite = mw;
        t.rs1 = rs1; t.rs2 = rs2; t.rd = rd; t.imm = imm;
        t.rd1 = 32'hA000_0000 | {27'd0, rs1};
        t.rd2 = 32'hB000_0000 | {27'd0, rs2};
        t.pc  = {1'b1, 3'd0, rd};
        return t;
    endfunction

    function automatic instr_t r_type(logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2, logic [6:0] f7);
        return mk(1'b1, 3'b010, f7, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, rs1, rs2, rd, 32'd0);
    endfunction

    function automatic instr_t lw(logic [4:0] rd, logic [4:0] rs1);
        return mk(1'b1, 3'b000, 7'd0, 3'b010, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, rs1, 5'd0, rd, 32'd0);
    endfunction

    // The rs2 field of an I-type is just imm[4:0] and is not a source.
    function automatic instr_t addi(logic [4:0] rd, logic [4:0] rs1, logic [31:0] imm);
        return mk(1'b1, 3'b011, imm[11:5], 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, rs1, imm[4:0], rd, imm);
    endfunction

    function automatic instr_t sw(logic [4:0] rs1, logic [4:0] rs2, logic [31:0] imm);
        return mk(1'b1, 3'b000, 7'd0, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, rs1, rs2, imm[4:0], imm);
    endfunction

    function automatic instr_t bubble();
        instr_t b;
        b = '0;
        return b;
    endfunction

    // Does the instruction in ID read the register a load in EX is producing?
    function automatic bit model_hazard(instr_t in);
        logic [4:0] srcs[$];
        if (!(m_ex.valid && m_ex.memread) || m_ex.rd == 5'd0 || !in.valid) return 1'b0;
        srcs.push_back(in.rs1);
        if (in.aluop == 3'b001 || in.aluop == 3'b010 || in.memwrite) srcs.push_back(in.rs2);
        foreach (srcs[i]) if (srcs[i] == m_ex.rd) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step(instr_t in, bit haz);
        if (in.flush) m_ex = bubble();
        else if (in.hold) m_ex = m_ex;
        else if (haz) begin
            m_ex = bubble();
            if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
        end else if (in.valid) begin
            m_ex = in;
            m_ex.flush = 1'b0;
            m_ex.hold = 1'b0;
        end else m_ex = bubble();
    endtask

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check("ex_valid", 128'(ex_valid), 128'(m_ex.valid));
        check("ex_ctrl",
              128'({ex_ALUOp, ex_Funct7, ex_Funct3, ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead, ex_MemWrite}),
              128'({m_ex.aluop, m_ex.f7, m_ex.f3, m_ex.alusrc, m_ex.memtoreg, m_ex.regwrite, m_ex.memread, m_ex.memwrite}));
        check("ex_idx", 128'({ex_rs1, ex_rs2, ex_rd}), 128'({m_ex.rs1, m_ex.rs2, m_ex.rd}));
        check("ex_data", 128'({ex_RD1, ex_RD2, ex_Imm}), 128'({m_ex.rd1, m_ex.rd2, m_ex.imm}));
        check("ex_pc", 128'(ex_PC), 128'(m_ex.pc));
        check("bubble_cnt", 128'(bubble_cnt), 128'(m_cnt));
    endtask

    task automatic drive(instr_t v);
        flush = v.flush; hold = v.hold; id_valid = v.valid;
        id_ALUOp = v.aluop; id_Funct7 = v.f7; id_Funct3 = v.f3;
        id_ALUSrc = v.alusrc; id_MemtoReg = v.memtoreg; id_RegWrite = v.regwrite;
        id_MemRead = v.memread; id_MemWrite = v.memwrite;
        id_rs1 = v.rs1; id_rs2 = v.rs2; id_rd = v.rd;
        id_RD1 = v.rd1; id_RD2 = v.rd2; id_Imm = v.imm; id_PC = v.pc;
    endtask

    // One pipeline cycle: drive ID after the falling edge, check stall before
    // the rising edge, advance the model, check EX just after the edge.
    task automatic cycle(instr_t v, output logic st);
        bit haz;
        @(negedge clk);
        drive(v);
        #1;
        haz = model_hazard(v);
        st = stall;
        check("stall", 128'(stall), 128'(v.hold | haz));
        @(posedge clk);
        model_step(v, haz);
        #1;
        check_outputs();
    endtask

    initial begin
        logic   st;
        instr_t v;
        int     guard;

        // Directed table: {instruction in ID, stall, ex_valid, ex_rd, bubble_cnt after edge}
        tbl[0]  = '{r_type(5'd3, 5'd1, 5'd2, 7'd0), 1'b0, 1'b1, 5'd3, 0}; // ADD x3,x1,x2
        tbl[1]  = '{lw(5'd5, 5'd1),                 1'b0, 1'b1, 5'd5, 0}; // LW x5
        tbl[2]  = '{addi(5'd6, 5'd5, 32'd4),        1'b1, 1'b0, 5'd0, 1}; // load-use -> bubble
        tbl[3]  = '{addi(5'd6, 5'd5, 32'd4),        1'b0, 1'b1, 5'd6, 1}; // consumer enters EX
        tbl[4]  = '{lw(5'd5, 5'd1),                 1'b0, 1'b1, 5'd5, 1};
        tbl[5]  = '{addi(5'd6, 5'd7, 32'd5),        1'b0, 1'b1, 5'd6, 1}; // rs2 field=5 unused
        tbl[6]  = '{lw(5'd5, 5'd1),                 1'b0, 1'b1, 5'd5, 1};
        tbl[7]  = '{sw(5'd8, 5'd5, 32'd0),          1'b1, 1'b0, 5'd0, 2}; // store data from load
        tbl[8]  = '{sw(5'd8, 5'd5, 32'd0),          1'b0, 1'b1, 5'd0, 2};
        tbl[9]  = '{lw(5'd0, 5'd1),                 1'b0, 1'b1, 5'd0, 2}; // LW x0
        tbl[10] = '{addi(5'd1, 5'd0, 32'd1),        1'b0, 1'b1, 5'd1, 2}; // x0 never hazards
        tbl[11] = '{lw(5'd5, 5'd1),                 1'b0, 1'b1, 5'd5, 2};
        tbl[12] = '{addi(5'd6, 5'd5, 32'd4),        1'b1, 1'b0, 5'd0, 2}; // + flush: no count
        tbl[12].in.flush = 1'b1;
        tbl[13] = '{lw(5'd5, 5'd1),                 1'b0, 1'b1, 5'd5, 2};
        tbl[14] = '{addi(5'd6, 5'd5, 32'd4),        1'b1, 1'b1, 5'd5, 2}; // + hold: frozen
        tbl[14].in.hold = 1'b1;
        tbl[15] = '{addi(5'd6, 5'd5, 32'd4),        1'b1, 1'b0, 5'd0, 3}; // hazard re-evaluated
        tbl[16] = '{r_type(5'd9, 5'd6, 5'd5, 7'h20), 1'b0, 1'b1, 5'd9, 3}; // SUB
        tbl[17] = '{r_type(5'd12, 5'd3, 5'd4, 7'd0), 1'b0, 1'b0, 5'd0, 3}; // not valid
        tbl[17].in.valid = 1'b0;
        tbl[18] = '{lw(5'd5, 5'd1),                 1'b0, 1'b1, 5'd5, 3};
        tbl[19] = '{addi(5'd6, 5'd5, 32'd4),        1'b0, 1'b0, 5'd0, 3}; // invalid consumer
        tbl[19].in.valid = 1'b0;

        // Power-on reset.
        reset = 1'b1;
        drive(bubble());
        m_ex = bubble();
        m_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            cycle(tbl[i].in, st);
            check($sformatf("tbl%0d_stall", i), 128'(st), 128'(tbl[i].exp_stall));
            check($sformatf("tbl%0d_valid", i), 128'(ex_valid), 128'(tbl[i].exp_valid));
            check($sformatf("tbl%0d_rd", i), 128'(ex_rd), 128'(tbl[i].exp_rd));
            check($sformatf("tbl%0d_cnt", i), 128'(bubble_cnt), 128'(tbl[i].exp_cnt));
        end

        // Hold for three cycles while ID keeps changing: EX must not move.
        cycle(r_type(5'd10, 5'd11, 5'd12, 7'd0), st);
        for (int i = 0; i < 3; i++) begin
            v = r_type(5'(20 + i), 5'(i), 5'(i + 1), 7'h20);
            v.hold = 1'b1;
            cycle(v, st);
            check("hold_rd", 128'(ex_rd), 128'(5'd10));
        end

        // Randomized traffic with small register indices so load-use pairs are common.
        for (int i = 0; i < 400; i++) begin
            v = mk(($urandom_range(7) != 0), 3'($urandom_range(3)), 7'($urandom), 3'($urandom),
                   1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(2) == 0),
                   ($urandom_range(3) == 0), 5'($urandom_range(7)), 5'($urandom_range(7)),
                   5'($urandom_range(7)), $urandom);
            v.rd1 = $urandom;
            v.rd2 = $urandom;
            v.pc = 9'($urandom);
            v.flush = ($urandom_range(9) == 0);
            v.hold = ($urandom_range(7) == 0);
            cycle(v, st);
        end

        // Asynchronous reset in mid-cycle with a live writing instruction in EX.
        cycle(r_type(5'd3, 5'd1, 5'd2, 7'd0), st);
        check("pre_reset_regwrite", 128'(ex_RegWrite), 128'(1'b1));
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        m_ex = bubble();
        m_cnt = 0;
        check_outputs();
        @(negedge clk);
        reset = 1'b0;
        cycle(r_type(5'd7, 5'd8, 5'd9, 7'd0), st);
        check("post_reset_rd", 128'(ex_rd), 128'(5'd7));

        // Drive the counter to saturation with load-use pairs, then one more.
        guard = 0;
        while (m_cnt < CNT_MAX && guard < 2 * CNT_MAX) begin
            cycle(lw(5'd5, 5'd1), st);
            cycle(addi(5'd6, 5'd5, 32'd4), st);
            guard++;
        end
        check("sat_reached", 128'(bubble_cnt), 128'(CNT_MAX));
        cycle(lw(5'd5, 5'd1), st);
        cycle(addi(5'd6, 5'd5, 32'd4), st);
        check("sat_stall", 128'(st), 128'(1'b1));
        check("sat_hold", 128'(bubble_cnt), 128'(CNT_MAX));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
